// File: rtl/axi_fifo_pkg.sv
// Shared types and helpers for the skip / delay-insert AXI-Stream FIFOs.
package axi_fifo_pkg;

  localparam int SKIP_WIDTH = 9;

  typedef enum logic {
    IDLE    = 1'b0,
    DISCARD = 1'b1
  } disc_state_t;

  // Unsigned minimum, used to clamp a discard to what is actually stored.
  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_out_pipe2.sv
// Two-stage registered AXI-Stream output with ready propagation.
// Stage 0 is loaded by the FIFO read; stage 1 drives the stream.
module axi_out_pipe2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  in_load,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  logic [1:0]            occ_reg;
  logic [DATA_WIDTH-1:0] data_d0;
  logic [DATA_WIDTH-1:0] data_d1;
  logic                  advance;

  assign advance   = out_ready | ~occ_reg[1];
  assign in_ready  = (occ_reg != 2'b11) | out_ready;
  assign out_valid = occ_reg[1];
  assign out_data  = data_d1;

  // NOTE: state is updated with <= so every register samples the pre-edge
  // values; with = the stage-1 copy would see the freshly loaded stage 0.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      occ_reg <= 2'b00;
      data_d0 <= '0;
      data_d1 <= '0;
    end else begin
      if (advance) begin
        occ_reg[1] <= occ_reg[0];
        data_d1    <= data_d0;
      end
      if (in_load) begin
        occ_reg[0] <= 1'b1;
        data_d0    <= in_data;
      end else if (advance) begin
        occ_reg[0] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_fifo_skip.sv
// AXI-Stream FIFO that drops `skip` oldest stored entries whenever skip changes.
// Define AXI_FIFO_SKIP_DROP_CNT_EN to add the 32-bit drop_count output.
module axi_fifo_skip
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic [SKIP_WIDTH-1:0] skip,
  output logic                  skip_busy,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
  ,
  output logic [31:0]           drop_count
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, occ;
  logic [PTR_W-1:0]      skip_s, disc_cnt, disc_cnt_d, n_drop;
  logic [SKIP_WIDTH-1:0] skip_d1, skip_d1_d;
  disc_state_t           state, state_d;
  logic                  full, empty, wr_en, rd_en, pipe_ready;

  assign occ    = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_en  = s_axis_tvalid & ~full;
  assign rd_en  = (state == IDLE) & ~empty & pipe_ready;
  assign skip_s = PTR_W'(skip);

  assign s_axis_tready = ~full;
  assign skip_busy     = (state == DISCARD);

  // NOTE: the storage array has no reset; clearing it would force flops instead
  // of distributed RAM, and stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d    = state;
    skip_d1_d  = skip_d1;
    disc_cnt_d = disc_cnt;
    n_drop     = '0;
    case (state)
      IDLE: begin
        if (skip != skip_d1) begin
          skip_d1_d  = skip;
          disc_cnt_d = skip_s;
          if (skip != '0) state_d = DISCARD;
        end
      end
      DISCARD: begin
        // Occupancy uses the registered write pointer: a same-cycle write waits.
        n_drop     = PTR_W'(min_u(32'(disc_cnt), 32'(occ)));
        disc_cnt_d = disc_cnt - n_drop;
        if (disc_cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state    <= IDLE;
      skip_d1  <= '0;
      disc_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_d;
      skip_d1  <= skip_d1_d;
      disc_cnt <= disc_cnt_d;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + n_drop + PTR_W'(rd_en);
    end
  end

`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (sync_reset) drop_count <= '0;
    else            drop_count <= drop_count + 32'(n_drop);
  end
`endif

  axi_out_pipe2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_pipe (
    .clk       (clk),
    .sync_reset(sync_reset),
    .in_load   (rd_en),
    .in_data   (mem[rd_ptr[ADDR_WIDTH-1:0]]),
    .in_ready  (pipe_ready),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axi_fifo_skip.sv
// Scoreboard bench for axi_fifo_skip: a queue-level model of accepted-but-unread
// samples plus an outstanding-drop count predicts every output beat.
`timescale 1ns/1ps
module tb_axi_fifo_skip;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [8:0]    skip;
  logic          skip_busy;
  logic          m_axis_tvalid, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
  logic [31:0]   drop_count;
`endif

  always #5 clk = ~clk;

  axi_fifo_skip #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .skip         (skip),
    .skip_busy    (skip_busy),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tready(m_axis_tready)
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: samples still owed to the output, in order, plus the
  // number of future accepts that a waiting discard will swallow.
  logic [31:0] pend[$];
  int owed         = 0;
  int last_skip    = 0;
  bit has_pending  = 1'b0;
  int pending_skip = 0;
  int model_drops  = 0;
  int n_pops       = 0;

  int cyc     = 0;
  bit lat_arm = 1'b0;
  int acc_cyc = -1;
  int vld_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A new skip value drops the oldest stored samples, but the (up to two)
  // samples already staged for output are kept; any shortfall waits for writes.
  function automatic void apply_skip(input int v);
    int staged, avail, d;
    if (v == last_skip) return;
    last_skip = v;
    staged = (pend.size() < 2) ? pend.size() : 2;
    avail  = pend.size() - staged;
    d      = (v < avail) ? v : avail;
    for (int i = 0; i < d; i++) pend.delete(staged);
    model_drops += d;
    owed = v - d;
  endfunction

  function automatic void model_accept(input logic [31:0] data);
    if (owed > 0) begin
      owed--;
      model_drops++;
      if (owed == 0 && has_pending) begin
        has_pending = 1'b0;
        apply_skip(pending_skip);
      end
    end else begin
      pend.push_back(data);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expected queue on every output handshake.
  always @(negedge clk) begin
    if (!sync_reset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        n_pops++;
        if (pend.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected output: got 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          check("m_axis_tdata", m_axis_tdata, pend.pop_front());
        end
      end
      if (lat_arm && vld_cyc < 0 && m_axis_tvalid) vld_cyc = cyc;
      if (s_axis_tvalid && s_axis_tready) begin
        if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
        model_accept(s_axis_tdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_skip(input int v);
    skip = 9'(v);
    if (owed > 0) begin
      has_pending  = 1'b1;
      pending_skip = v;
    end else begin
      apply_skip(v);
    end
  endtask

  // rmode: 0 hold tready low, 1 hold high, 2 randomise each cycle.
  task automatic write_burst(input int n, input int vprob, input int rmode,
                             input bit seq, input int base);
    int sent = 0;
    if (rmode == 0) m_axis_tready = 1'b0;
    if (rmode == 1) m_axis_tready = 1'b1;
    for (int c = 0; c < 20000 && sent < n; c++) begin
      s_axis_tvalid = ($urandom_range(99) < 32'(vprob));
      s_axis_tdata  = seq ? 32'(base + sent) : 32'($urandom);
      if (rmode == 2) m_axis_tready = 1'($urandom_range(1));
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) sent++;
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (sent < n) check("write_burst accepted count", 32'(sent), 32'(n));
  endtask

  // Stop writing and wait until the model says the DUT is idle: drained when
  // tready is high, pipeline filled when low, and no discard unless one is owed.
  task automatic quiesce(input bit rdy);
    int stable = 0;
    m_axis_tready = rdy;
    for (int c = 0; c < 4000 && stable < 8; c++) begin
      @(negedge clk);
      if ((!rdy || pend.size() == 0) && (owed > 0 || !skip_busy)) stable++;
      else stable = 0;
      tick();
    end
    if (stable < 8) check("quiesce settled", 32'(stable), 32'd8);
    check("skip_busy when settled", 32'(skip_busy), 32'(owed > 0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, busy_cnt, p0;
    bit early_low;

    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    skip          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset m_axis_tdata", m_axis_tdata, 32'd0);
    check("reset s_axis_tready", 32'(s_axis_tready), 32'd1);
    check("reset skip_busy", 32'(skip_busy), 32'd0);
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
    check("reset drop_count", drop_count, 32'd0);
`endif
    sync_reset = 1'b0;
    tick();

    // 0..9 straight through; first beat three cycles after first accept.
    lat_arm = 1'b1;
    write_burst(10, 100, 1, 1'b1, 0);
    quiesce(1'b1);
    lat_arm = 1'b0;
    check("first-beat latency", 32'(vld_cyc - acc_cyc), 32'd3);
    check("0..9 beat count", 32'(n_pops), 32'd10);

    // Fill with tready low. Two entries sit in the output stages, so the RAM
    // holds 256 after the 258th accept and tready must fall then.
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    acc = 0;
    early_low = 1'b0;
    for (int c = 0; c < 400 && acc < 258; c++) begin
      s_axis_tdata = 32'(1000 + acc);
      @(negedge clk);
      if (s_axis_tready) acc++;
      else early_low = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    check("fill: tready high before full", 32'(early_low), 32'd0);
    @(negedge clk);
    check("fill: tready low when full", 32'(s_axis_tready), 32'd0);
    tick();
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    @(negedge clk);
    check("fill: tready back after one pop", 32'(s_axis_tready), 32'd1);
    tick();
    quiesce(1'b1);

    // 20 queued, tready low, skip=5: staged 0/1 survive, then 7..19.
    write_burst(20, 100, 0, 1'b1, 100);
    quiesce(1'b0);
    set_skip(5);
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (skip_busy) busy_cnt++;
    end
    tick();
    check("skip=5 busy cycles", 32'(busy_cnt), 32'd2);
    p0 = n_pops;
    quiesce(1'b1);
    check("skip=5 beats out", 32'(n_pops - p0), 32'd15);

    // Empty FIFO, skip=300: discard waits on writes, v300..v309 come out.
    set_skip(300);
    tick();
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (skip_busy) busy_cnt++;
    end
    tick();
    check("skip=300 busy while empty", 32'(busy_cnt), 32'd20);
    p0 = n_pops;
    write_burst(299, 100, 1, 1'b0, 0);
    repeat (5) tick();
    check("skip=300 busy with one owed", 32'(skip_busy), 32'd1);
    check("skip=300 nothing out yet", 32'(n_pops - p0), 32'd0);
    write_burst(11, 100, 1, 1'b0, 0);
    quiesce(1'b1);
    check("skip=300 beats out", 32'(n_pops - p0), 32'd10);

    // 4 then 8 while the first discard is still waiting: 12 dropped in total.
    p0 = n_pops;
    set_skip(4);
    repeat (3) tick();
    set_skip(8);
    write_burst(4, 100, 1, 1'b0, 0);
    quiesce(1'b1);
    write_burst(20, 100, 1, 1'b0, 0);
    quiesce(1'b1);
    check("skip 4->8 beats out of 24", 32'(n_pops - p0), 32'd12);
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
    check("drop_count after 4->8", drop_count, 32'(model_drops));
`endif

    // Reset in the middle of a discard with 50 entries queued.
    write_burst(50, 100, 0, 1'b1, 5000);
    quiesce(1'b0);
    set_skip(100);
    repeat (4) tick();
    check("mid-discard busy", 32'(skip_busy), 32'd1);
    sync_reset = 1'b1;
    tick();
    check("after reset m_axis_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("after reset skip_busy", 32'(skip_busy), 32'd0);
    check("after reset s_axis_tready", 32'(s_axis_tready), 32'd1);
    pend.delete();
    owed        = 0;
    has_pending = 1'b0;
    last_skip   = 0;
    model_drops = 0;
    sync_reset  = 1'b0;
    set_skip(100);
    repeat (2) tick();
    check("discard restarts after reset", 32'(skip_busy), 32'd1);
    p0 = n_pops;
    write_burst(110, 100, 1, 1'b0, 0);
    quiesce(1'b1);
    check("post-reset beats out", 32'(n_pops - p0), 32'd10);

    // Random traffic, backpressure and skip changes.
    for (int p = 0; p < 12; p++) begin
      write_burst(int'($urandom_range(80, 5)), int'($urandom_range(100, 30)), 2, 1'b0, 0);
      quiesce(1'($urandom_range(1)));
      if (owed == 0) begin
        set_skip(int'($urandom_range(40)));
        tick();
      end
    end
    write_burst(owed + 20, 100, 1, 1'b0, 0);
    quiesce(1'b1);
    check("final expected queue empty", 32'(pend.size()), 32'd0);
    check("final skip_busy", 32'(skip_busy), 32'd0);
`ifdef AXI_FIFO_SKIP_DROP_CNT_EN
    check("final drop_count", drop_count, 32'(model_drops));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
